rgb_led_pwm: RTL and testbench
==============================

RGB_LED_PWM -- requirements
Module: rgb_led_pwm

Interface
REQ-001 SHALL have parameter NUM_CH, default 1: number of independent RGB LED channels.
REQ-002 SHALL have parameter PWM_W, default 8: brightness resolution; PWM period is 2^PWM_W clk cycles.
REQ-003 SHALL have parameter BLINK_HALF, default 50_000_000: clk cycles per blink half-period (1 Hz at 100 MHz).
REQ-004 SHALL have port clk, input, 1: single clock, all state on posedge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port color, input, 2*NUM_CH: per-channel code, channel i at [2i+1:2i]; 00 off, 01 red, 10 green, 11 blue.
REQ-007 SHALL have port duty, input, PWM_W: shared brightness request.
REQ-008 SHALL have port blink, input, NUM_CH: per-channel blink enable.
REQ-009 SHALL have port led_out, output, 3*NUM_CH: per-channel {R,G,B}, channel i at [3i+2:3i], registered.
REQ-010 SHALL have port period_start, output, 1: one-cycle pulse at PWM period start, registered.

Function
REQ-011 SHALL run free counter pwm_cnt, PWM_W bits, incrementing every cycle and wrapping from 2^PWM_W-1 to 0.
REQ-012 SHALL load duty into shadow duty_act only in the cycle pwm_cnt == 2^PWM_W-1, so a new duty takes effect at the next period start; mid-period duty changes SHALL NOT alter the current period.
REQ-013 SHALL define pwm_on = (pwm_cnt < duty_act): duty 0 never on; duty 2^PWM_W-1 on for 2^PWM_W-1 of 2^PWM_W cycles.
REQ-014 SHALL decode color per channel: 01 -> 100, 10 -> 010, 11 -> 001, 00 -> 000.
REQ-015 SHALL register led_out[i] = decode(color[i]) gated by pwm_on and by the blink mask (REQ-017); latency from color/pwm_cnt to led_out is exactly 1 cycle.
REQ-016 SHALL assert period_start for exactly one cycle, the cycle after pwm_cnt == 0 is sampled (i.e. aligned with the first led_out of each period).
REQ-017 With blink enabled (see Configuration): counter blink_cnt counts 0..BLINK_HALF-1 and wraps; blink_phase toggles on each wrap; channel i with blink[i]=1 SHALL force led_out[i]=000 while blink_phase=0; blink[i]=0 channels unaffected.
REQ-018 Changing blink[i] SHALL NOT reset blink_cnt or blink_phase; all channels share one phase.
REQ-019 Simultaneous color change and duty load in the wrap cycle SHALL both be honoured: next led_out uses new color with the old duty_act comparison against pwm_cnt == 2^PWM_W-1, following cycle uses new duty_act.

Reset
REQ-020 On rst_n low, asynchronously: pwm_cnt=0, duty_act=0, led_out=0, period_start=0, blink_cnt=0, blink_phase=1.
REQ-021 After rst_n deasserts, counting SHALL start on the first posedge; reset mid-period SHALL discard the current period and the pending duty.

Configuration
REQ-022 Macro RGB_LED_BLINK_EN defined: REQ-017/018 blink logic compiled in.
REQ-023 Macro RGB_LED_BLINK_EN undefined: no blink counter or phase register; blink input ignored; led_out gated by pwm_on only.

Structure
REQ-024 Shared package rgb_led_pkg SHALL hold the 2-bit color code constants and the 3-bit {R,G,B} pattern constants.
REQ-025 PWM counter, shadow register and comparator SHALL be one sub-module, pwm_gen, instantiated once and shared across channels.

Verification (PWM_W=4, BLINK_HALF=8, NUM_CH=2)
REQ-026 Reset: rst_n low mid-run -> all outputs 0 immediately, blink_phase=1 after release.
REQ-027 color=01 ch0, duty=4 held -> led_out[2:0]=100 for 4 of every 16 cycles, 000 otherwise; period_start once per 16 cycles.
REQ-028 duty changed 4 -> 12 at pwm_cnt=5 -> current period keeps 4 on-cycles, next period has 12.
REQ-029 duty=0 -> led_out stays 000; duty=15 -> 15 on, 1 off per period.
REQ-030 blink=01, both channels color=10, duty=15 -> ch0 dark for 8 cycles every 16, ch1 unaffected; without RGB_LED_BLINK_EN ch0 matches ch1.
REQ-031 color 01 -> 11 on ch1 at pwm_cnt=0 -> led_out[5:3] becomes 001 exactly one cycle later.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// Purpose: shared colour codes, {R,G,B} patterns and decode helper for the RGB LED PWM block.
// Latency: none (package only; the decode helper is combinational).
// Backpressure: not applicable.
package rgb_led_pkg;

  // 2-bit per-channel colour request codes
  localparam logic [1:0] COLOR_OFF   = 2'b00;
  localparam logic [1:0] COLOR_RED   = 2'b01;
  localparam logic [1:0] COLOR_GREEN = 2'b10;
  localparam logic [1:0] COLOR_BLUE  = 2'b11;

  // 3-bit {R,G,B} drive patterns
  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;

  // Map a colour code onto its {R,G,B} pattern
  function automatic logic [2:0] color_decode(input logic [1:0] code);
    logic [2:0] pat;
    pat = RGB_OFF;
    case (code)
      COLOR_RED:   pat = RGB_RED;
      COLOR_GREEN: pat = RGB_GREEN;
      COLOR_BLUE:  pat = RGB_BLUE;
      default:     pat = RGB_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Purpose: free-running PWM period counter, period-aligned duty shadow and on/off comparator.
// Latency: pwm_on/cnt_zero are combinational from the counter; duty is taken at the next period start.
// Backpressure: none; free-running, no handshake.
module pwm_gen
  import rgb_led_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_on,
  output logic             cnt_zero
);

  localparam logic [PWM_W-1:0] CNT_MAX = '1;
  localparam logic [PWM_W-1:0] CNT_ONE = PWM_W'(1);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_act;

  // Period counter wraps naturally at 2^PWM_W; duty is only sampled on the last
  // count so a mid-period change never reshapes the period in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      duty_act <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + CNT_ONE;
      if (pwm_cnt == CNT_MAX) begin
        duty_act <= duty;
      end
    end
  end

  // duty_act of 0 is never on; all-ones leaves exactly one dark cycle per period
  always_comb begin
    pwm_on   = (pwm_cnt < duty_act);
    cnt_zero = (pwm_cnt == '0);
  end

endmodule

// File: rtl/rgb_led_pwm.sv
// Purpose: per-channel RGB LED driver sharing one PWM generator; optional blink gating when RGB_LED_BLINK_EN is defined.
// Latency: 1 clk from color/PWM count (and blink phase) to led_out and period_start.
// Backpressure: none; outputs update every clk.
module rgb_led_pwm
  import rgb_led_pkg::*;
#(
  parameter int NUM_CH     = 1,
  parameter int PWM_W      = 8,
  parameter int BLINK_HALF = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NUM_CH-1:0]   color,
  input  logic [PWM_W-1:0]      duty,
  input  logic [NUM_CH-1:0]     blink,
  output logic [3*NUM_CH-1:0]   led_out,
  output logic                  period_start
);

  logic              pwm_on;
  logic              cnt_zero;
  logic [NUM_CH-1:0] chan_en;
  logic [3*NUM_CH-1:0] led_nxt;

  pwm_gen #(
    .PWM_W (PWM_W)
  ) u_pwm_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .duty     (duty),
    .pwm_on   (pwm_on),
    .cnt_zero (cnt_zero)
  );

`ifdef RGB_LED_BLINK_EN
  localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_HALF - 1);
  localparam logic [BCW-1:0] BLINK_ONE  = BCW'(1);

  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;

  // One shared blink timebase; phase starts lit so blinking channels show
  // immediately after reset. Toggling blink[i] never disturbs this counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_ONE;
    end
  end

  // Blinking channels are dark during phase 0; others always enabled
  always_comb begin
    chan_en = blink_phase ? {NUM_CH{1'b1}} : ~blink;
  end
`else
  logic blink_unused;

  // No blink hardware in this build: every channel follows the PWM only
  always_comb begin
    blink_unused = ^blink;
    chan_en      = {NUM_CH{1'b1}};
  end
`endif

  // Decode each channel's colour and gate it with PWM on-time and blink mask
  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pwm_on && chan_en[i]) begin
        led_nxt[3*i +: 3] = color_decode(color[2*i +: 2]);
      end
    end
  end

  // Register the LED drive and the period marker so they stay cycle-aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out      <= '0;
      period_start <= 1'b0;
    end else begin
      led_out      <= led_nxt;
      period_start <= cnt_zero;
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Purpose: directed self-checking bench for rgb_led_pwm with NUM_CH=2, PWM_W=4, BLINK_HALF=8.
// Latency: expects led_out/period_start one clk after the sampled PWM count.
// Backpressure: not applicable.
module tb_rgb_led_pwm;

`ifdef RGB_LED_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] color;
  logic [3:0] duty;
  logic [1:0] blink;
  logic [5:0] led_out;
  logic       period_start;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rgb_led_pwm #(
    .NUM_CH     (2),
    .PWM_W      (4),
    .BLINK_HALF (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .color        (color),
    .duty         (duty),
    .blink        (blink),
    .led_out      (led_out),
    .period_start (period_start)
  );

  function automatic logic [2:0] dec(input logic [1:0] c);
    case (c)
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input int per, input int j,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s period=%0d step=%0d observed=%0h expected=%0h", tag, per, j, obs, exp);
    end
  endtask

  // One 16-cycle PWM period. Called with the PWM counter at 0; step j checks the
  // output produced from count j. exp_d is the duty in force for this period.
  // The blink phase is lit for counts 0..7 and dark for 8..15 because the
  // 8-cycle half-period and the 16-cycle PWM period both restart at reset.
  task automatic run_period(input int per, input int exp_d, input logic [3:0] col,
                            input logic [1:0] blk, input int chg_at,
                            input logic [3:0] new_duty);
    logic [5:0] exp;
    logic       on;
    color = col;
    blink = blk;
    for (int j = 0; j < 16; j++) begin
      if (j == chg_at) duty = new_duty;
      @(posedge clk);
      #1;
      exp = '0;
      for (int i = 0; i < 2; i++) begin
        on = (j < exp_d);
        if (BLINK_ON && blk[i] && j >= 8) on = 1'b0;
        if (on) exp[3*i +: 3] = dec(col[2*i +: 2]);
      end
      chk("led_out", per, j, 32'(led_out), 32'(exp));
      chk("period_start", per, j, 32'(period_start), (j == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    color = 4'b0000;
    duty  = 4'd0;
    blink = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led_out", 0, 0, 32'(led_out), 32'd0);
    chk("reset_period_start", 0, 0, 32'(period_start), 32'd0);

    // ch0 red, duty 4; first period still runs with the reset duty of 0
    color = 4'b0001;
    duty  = 4'd4;
    rst_n = 1'b1;
    run_period(1, 0, 4'b0001, 2'b00, -1, 4'd0);
    run_period(2, 4, 4'b0001, 2'b00, -1, 4'd0);
    run_period(3, 4, 4'b0001, 2'b00, -1, 4'd0);

    // duty 4 -> 12 while the counter is at 5: takes effect next period
    run_period(4, 4, 4'b0001, 2'b00, 5, 4'd12);
    run_period(5, 12, 4'b0001, 2'b00, -1, 4'd0);

    // duty 0 gives a fully dark period; duty 15 leaves one dark cycle
    run_period(6, 12, 4'b0001, 2'b00, 0, 4'd0);
    run_period(7, 0, 4'b0001, 2'b00, 3, 4'd15);
    run_period(8, 15, 4'b0101, 2'b00, -1, 4'd0);

    // ch1 red -> blue exactly at count 0 shows blue on the very next output
    run_period(9, 15, 4'b1101, 2'b00, -1, 4'd0);

    // both green, blink on ch0 only
    run_period(10, 15, 4'b1010, 2'b01, -1, 4'd0);
    run_period(11, 15, 4'b1010, 2'b01, -1, 4'd0);

    // reset mid-period while outputs are active
    @(posedge clk);
    #1;
    chk("pre_reset_led_out", 12, 0, 32'(led_out), 32'h12);
    chk("pre_reset_period_start", 12, 0, 32'(period_start), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_led_out", 12, 0, 32'(led_out), 32'd0);
    chk("async_reset_period_start", 12, 0, 32'(period_start), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // pending duty discarded, then blink restarts in the lit phase
    run_period(13, 0, 4'b1010, 2'b01, -1, 4'd0);
    run_period(14, 15, 4'b1010, 2'b01, -1, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
